// File: rtl/fsm_quicksort_packetizer_if.sv
// Word-stream handshake bundle for the quicksort packetizer.
//   in_vld/in_dat/in_flush : producer word stream and packet-close request
//   in_rdy                 : packetizer can take the input word this cycle
//   out_vld/out_sop/out_eop/out_dat : framed word stream toward the sorter
//   out_rdy                : downstream accepts the output word
// slave  = packetizer side, master = producer/consumer (bench) side.
interface fsm_quicksort_packetizer_if #(
  parameter int W = 32
);
  logic         in_vld;
  logic [W-1:0] in_dat;
  logic         in_flush;
  logic         in_rdy;
  logic         out_vld;
  logic         out_sop;
  logic         out_eop;
  logic [W-1:0] out_dat;
  logic         out_rdy;

  modport slave (
    input  in_vld, in_dat, in_flush, out_rdy,
    output in_rdy, out_vld, out_sop, out_eop, out_dat
  );

  modport master (
    output in_vld, in_dat, in_flush, out_rdy,
    input  in_rdy, out_vld, out_sop, out_eop, out_dat
  );
endinterface

// File: rtl/fsm_quicksort_packetizer.sv
// Transmit-side framer: packs an unframed word stream into packets of
// 1..N words with sop/eop. One word is parked in a hold stage until its
// eop is known, so out_eop is correct the first cycle a word is shown.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   io       : handshake bundle (slave modport), all out_* registered
//   busy     : a word is held or an output word is pending
module fsm_quicksort_packetizer #(
  parameter int N = 16,
  parameter int W = 32
) (
  input  logic clk,
  input  logic rst,
  fsm_quicksort_packetizer_if.slave io,
  output logic busy
);
  localparam int PW = $clog2(N);

  // Hold stage occupancy; a resolved held word is always an eop word, so
  // hold_eop is implied by H_RES.
  typedef enum logic [1:0] {H_EMPTY, H_UNRES, H_RES} hold_e;

  hold_e         hold_q, hold_d;
  logic [W-1:0]  hold_dat_q, hold_dat_d;
  logic          hold_sop_q, hold_sop_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          out_vld_q, out_vld_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic [W-1:0]  out_dat_q, out_dat_d;

  logic out_free, in_rdy, acc, flush_sa, new_res, xfer;

  always_comb begin
    out_free = !out_vld_q || io.out_rdy;
    in_rdy   = (hold_q == H_EMPTY) || out_free;
    acc      = io.in_vld && in_rdy;
    flush_sa = io.in_flush && !io.in_vld;
    new_res  = (pos_q == PW'(N - 1)) || io.in_flush;
    // Resolved word leaves when output frees; an accept always displaces
    // whatever is held (in_rdy already guarantees out_free then).
    xfer     = ((hold_q == H_RES) && out_free) || (acc && (hold_q != H_EMPTY));

    hold_d     = hold_q;
    hold_dat_d = hold_dat_q;
    hold_sop_d = hold_sop_q;
    pos_d      = pos_q;
    out_vld_d  = out_vld_q;
    out_sop_d  = out_sop_q;
    out_eop_d  = out_eop_q;
    out_dat_d  = out_dat_q;

    if (xfer) begin
      out_vld_d = 1'b1;
      out_sop_d = hold_sop_q;
      out_eop_d = (hold_q == H_RES);  // displaced unresolved word gets eop=0
      out_dat_d = hold_dat_q;
    end else if (io.out_rdy) begin
      out_vld_d = 1'b0;
    end

    if (acc) begin
      hold_d     = new_res ? H_RES : H_UNRES;
      hold_dat_d = io.in_dat;
      hold_sop_d = (pos_q == '0);
      pos_d      = new_res ? '0 : pos_q + PW'(1);
    end else begin
      if (xfer)
        hold_d = H_EMPTY;
      else if (flush_sa && hold_q == H_UNRES)
        hold_d = H_RES;
      if (flush_sa)
        pos_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= H_EMPTY;
      hold_dat_q <= '0;
      hold_sop_q <= 1'b0;
      pos_q      <= '0;
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_dat_q <= hold_dat_d;
      hold_sop_q <= hold_sop_d;
      pos_q      <= pos_d;
      out_vld_q  <= out_vld_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_dat_q  <= out_dat_d;
    end
  end

  assign io.in_rdy  = in_rdy;
  assign io.out_vld = out_vld_q;
  assign io.out_sop = out_sop_q;
  assign io.out_eop = out_eop_q;
  assign io.out_dat = out_dat_q;
  assign busy       = (hold_q != H_EMPTY) || out_vld_q;
endmodule

// File: tb/tb_fsm_quicksort_packetizer.sv
module tb_fsm_quicksort_packetizer;
  localparam int N = 16;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_assert = 0;
  int   n_fail   = 0;

  fsm_quicksort_packetizer_if #(.W(W)) bus ();

  fsm_quicksort_packetizer #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .io   (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Observed and expected output words: {sop, eop, dat}
  logic [W+1:0] obs_q[$];
  logic [W+1:0] exp_q[$];

  always @(negedge clk)
    if (!rst && bus.out_vld && bus.out_rdy)
      obs_q.push_back({bus.out_sop, bus.out_eop, bus.out_dat});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expw(input logic sop, input logic eop, input logic [W-1:0] dat);
    exp_q.push_back({sop, eop, dat});
  endtask

  task automatic check_out(input string tag);
    int n;
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word until accepted (bounded), then drop in_vld.
  task automatic send(input logic [W-1:0] dat, input logic flush);
    int t = 0;
    bus.in_vld   = 1'b1;
    bus.in_dat   = dat;
    bus.in_flush = flush;
    @(negedge clk);
    while (!bus.in_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_assert++;
      n_fail++;
      $error("FAIL send_timeout: observed in_rdy=0 expected in_rdy=1");
    end
    @(posedge clk);
    #1;
    bus.in_vld   = 1'b0;
    bus.in_flush = 1'b0;
  endtask

  task automatic flush_sa();
    bus.in_vld   = 1'b0;
    bus.in_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_flush = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_out_vld"}, 64'(bus.out_vld), 64'd0);
    chk({tag, "_out_sop"}, 64'(bus.out_sop), 64'd0);
    chk({tag, "_out_eop"}, 64'(bus.out_eop), 64'd0);
    chk({tag, "_out_dat"}, 64'(bus.out_dat), 64'd0);
    chk({tag, "_in_rdy"},  64'(bus.in_rdy),  64'd1);
    chk({tag, "_busy"},    64'(busy),        64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_vld   = 1'b0;
    bus.in_dat   = '0;
    bus.in_flush = 1'b0;
    bus.out_rdy  = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset state
    chk_reset_state("reset");
    @(posedge clk);
    #1;

    // Two full packets back to back, words 0..31
    for (int i = 0; i < 32; i++) send(W'(i), 1'b0);
    idle(4);
    for (int i = 0; i < 32; i++) expw((i % N) == 0, (i % N) == N - 1, W'(i));
    check_out("stream32");
    chk("stream32_busy", 64'(busy), 64'd0);

    // A,B,C then standalone flush; D restarts at sop; flush D out alone
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b0);
    flush_sa();
    send(32'hD, 1'b0);
    idle(3);
    chk("unres_d_busy", 64'(busy), 64'd1);
    flush_sa();
    idle(4);
    expw(1'b1, 1'b0, 32'hA);
    expw(1'b0, 1'b0, 32'hB);
    expw(1'b0, 1'b1, 32'hC);
    expw(1'b1, 1'b1, 32'hD);
    check_out("abc_flush");

    // Word accompanied by flush forms a 1-word packet
    send(32'h55, 1'b1);
    idle(4);
    expw(1'b1, 1'b1, 32'h55);
    check_out("flush_word");

    // Flush with hold empty: no output, not busy; then a normal packet
    flush_sa();
    @(negedge clk);
    chk("empty_flush_busy", 64'(busy), 64'd0);
    idle(2);
    chk("empty_flush_noout", 64'(obs_q.size()), 64'd0);
    for (int i = 0; i < 16; i++) send(W'(32'h100 + i), 1'b0);
    idle(4);
    for (int i = 0; i < 16; i++) expw(i == 0, i == 15, W'(32'h100 + i));
    check_out("after_empty_flush");

    // Backpressure: 2 words accepted, third stalls until out_rdy returns
    bus.out_rdy = 1'b0;
    send(32'h201, 1'b0);
    send(32'h202, 1'b0);
    bus.in_vld = 1'b1;
    bus.in_dat = 32'h203;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_in_rdy_%0d", i), 64'(bus.in_rdy), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.out_rdy = 1'b1;
    send(32'h203, 1'b0);
    flush_sa();
    idle(4);
    expw(1'b1, 1'b0, 32'h201);
    expw(1'b0, 1'b0, 32'h202);
    expw(1'b0, 1'b1, 32'h203);
    check_out("backpressure");

    // Reset mid-packet after 5 words
    for (int i = 0; i < 5; i++) send(W'(32'h300 + i), 1'b0);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state("midrst");
    @(posedge clk);
    #1;
    send(32'h77, 1'b0);
    flush_sa();
    idle(4);
    for (int i = 0; i < 4; i++) expw(i == 0, 1'b0, W'(32'h300 + i));
    expw(1'b1, 1'b1, 32'h77);
    check_out("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
